// File: rtl/bootctrl_regs.sv
// bootctrl_regs
// Register-bus responder that owns the core boot controls: DRAM base,
// entry PC, a hold-reset level and a START/STOP sequencer that runs a
// timed core reset pulse before releasing the core to run.
//
// Optional feature macro: BOOTCTRL_CYCLE_COUNTER_EN
//   defined   -> 32-bit RUN cycle counter readable at offset 0x10
//   undefined -> no counter logic, offset 0x10 reads as 0

module bootctrl_regs #(
  parameter logic [15:0] BASE_ADDR     = 16'h1000,
  parameter int unsigned RST_CYCLES    = 16,
  parameter logic [31:0] DRAMBASE_INIT = 32'h0000_0000,
  parameter logic [31:0] ENTRYPC_INIT  = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA,
  output logic        core_rst,
  output logic        core_run,
  output logic [31:0] dram_base,
  output logic [31:0] entry_pc
);

  // Word offsets inside the 32-byte window (addr[4:2])
  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CTRL     = 3'd1;
  localparam logic [2:0] OFF_DRAMBASE = 3'd2;
  localparam logic [2:0] OFF_ENTRYPC  = 3'd3;
  localparam logic [2:0] OFF_CYCLES   = 3'd4;

  // The pulse counter counts down from RST_CYCLES-1 to 0, giving
  // exactly RST_CYCLES cycles in PULSE.
  localparam logic [7:0] CNT_LOAD = 8'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hold_q, hold_d;
  logic [31:0] dramBase_q, dramBase_d;
  logic [31:0] entryPc_q, entryPc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cycleCount;

  logic        wrHit;
  logic        rdHit;
  logic [2:0]  wrOff;
  logic [2:0]  rdOff;
  logic        ctrlWr;
  logic        startReq;
  logic        stopReq;
  logic        effHold;
  logic        unusedAddrBits;

  // Byte-lane merge: lanes with their enable set take the new data
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] result;
    result = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        result[8*i +: 8] = newVal[8*i +: 8];
      end
    end
    return result;
  endfunction

  // Window decode; the window is 32-byte aligned so only addr[15:5] compare
  assign wrHit = WREN && (WRADDR[15:5] == BASE_ADDR[15:5]);
  assign rdHit = RDEN && (RDADDR[15:5] == BASE_ADDR[15:5]);
  assign wrOff = WRADDR[4:2];
  assign rdOff = RDADDR[4:2];

  // Byte offset bits within a word carry no meaning on this bus
  assign unusedAddrBits = ^{WRADDR[1:0], RDADDR[1:0]};

  // CTRL only acts when the low byte lane is enabled; the hold level seen by
  // the sequencer is the freshly written bit when CTRL is written this cycle
  assign ctrlWr   = wrHit && (wrOff == OFF_CTRL) && BYTEEN[0];
  assign startReq = ctrlWr && WDATA[1];
  assign stopReq  = ctrlWr && WDATA[2];
  assign effHold  = ctrlWr ? WDATA[0] : hold_q;

  // Next-state for the software-visible RW registers
  always_comb begin
    hold_d     = hold_q;
    dramBase_d = dramBase_q;
    entryPc_d  = entryPc_q;
    if (wrHit) begin
      case (wrOff)
        OFF_CTRL: begin
          if (BYTEEN[0]) begin
            hold_d = WDATA[0];
          end
        end
        OFF_DRAMBASE: begin
          dramBase_d = mergeBytes(dramBase_q, WDATA, BYTEEN);
        end
        OFF_ENTRYPC: begin
          entryPc_d = mergeBytes(entryPc_q, WDATA, BYTEEN) & 32'hFFFF_FFFC;
        end
        default: begin
        end
      endcase
    end
  end

  // Sequencer next-state: hold wins over everything, STOP wins over START,
  // START in PULSE reloads the pulse counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (effHold) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (startReq) begin
            state_d = ST_PULSE;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_PULSE: begin
          if (stopReq) begin
            state_d = ST_IDLE;
          end else if (startReq) begin
            cnt_d = CNT_LOAD;
          end else if (cnt_q == 8'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_RUN: begin
          if (stopReq) begin
            state_d = ST_IDLE;
          end else if (startReq) begin
            state_d = ST_PULSE;
            cnt_d   = CNT_LOAD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef BOOTCTRL_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;

  // RUN cycle counter: cleared on entry to RUN, counts while in RUN, wraps
  always_comb begin
    cycles_d = cycles_q;
    if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
      cycles_d = 32'd0;
    end else if (state_q == ST_RUN) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycleCount = cycles_q;
`else
  assign cycleCount = 32'd0;
`endif

  // Read mux: RDATA is loaded only on RDEN and holds otherwise; values are
  // taken before this cycle's write lands, so read-during-write sees old data
  always_comb begin
    rdata_d = rdata_q;
    if (RDEN) begin
      rdata_d = 32'd0;
      if (rdHit) begin
        case (rdOff)
          OFF_STATUS:   rdata_d = {29'd0, (state_q == ST_PULSE), hold_q, (state_q == ST_RUN)};
          OFF_CTRL:     rdata_d = {31'd0, hold_q};
          OFF_DRAMBASE: rdata_d = dramBase_q;
          OFF_ENTRYPC:  rdata_d = entryPc_q;
          OFF_CYCLES:   rdata_d = cycleCount;
          default:      rdata_d = 32'd0;
        endcase
      end
    end
  end

  // State and register file update with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      hold_q     <= 1'b1;
      dramBase_q <= DRAMBASE_INIT;
      entryPc_q  <= ENTRYPC_INIT & 32'hFFFF_FFFC;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      dramBase_q <= dramBase_d;
      entryPc_q  <= entryPc_d;
      rdata_q    <= rdata_d;
    end
  end

  assign RDATA     = rdata_q;
  assign core_rst  = (state_q != ST_RUN);
  assign core_run  = (state_q == ST_RUN);
  assign dram_base = dramBase_q;
  assign entry_pc  = entryPc_q;

endmodule

// File: tb/tb_bootctrl_regs.sv
// tb_bootctrl_regs
// Self-checking bench for bootctrl_regs: directed scenarios followed by
// randomized bus traffic, all checked against a behavioural model.
// Honours BOOTCTRL_CYCLE_COUNTER_EN the same way as the design.

module tb_bootctrl_regs;

  localparam logic [15:0] BASE = 16'h1000;
  localparam int          NCYC = 16;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;
  logic        core_rst;
  logic        core_run;
  logic [31:0] dram_base;
  logic [31:0] entry_pc;

  int errCount   = 0;
  int checkCount = 0;

  // Behavioural model: mode 0 = idle, 1 = pulse, 2 = run
  int          mMode;
  int          mPulseLeft;
  logic        mHold;
  logic [31:0] mDram;
  logic [31:0] mEntry;
  logic [31:0] mRdata;
  logic [31:0] mRunCycles;

  always #5 ACLK = ~ACLK;

  bootctrl_regs #(
    .BASE_ADDR    (BASE),
    .RST_CYCLES   (NCYC),
    .DRAMBASE_INIT(32'h0000_0000),
    .ENTRYPC_INIT (32'h0000_0000)
  ) dut (
    .ACLK     (ACLK),
    .ARST     (ARST),
    .WRADDR   (WRADDR),
    .BYTEEN   (BYTEEN),
    .WREN     (WREN),
    .WDATA    (WDATA),
    .RDADDR   (RDADDR),
    .RDEN     (RDEN),
    .RDATA    (RDATA),
    .core_rst (core_rst),
    .core_run (core_run),
    .dram_base(dram_base),
    .entry_pc (entry_pc)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Word index inside the window, or -1 when the address is outside it
  function automatic int windowWord(input logic [15:0] addr);
    int a;
    a = int'(addr) - int'(BASE);
    if (a < 0 || a > 31) return -1;
    return a / 4;
  endfunction

  function automatic logic [31:0] modelRead(input logic [15:0] addr);
    logic [31:0] v;
    v = 32'd0;
    case (windowWord(addr))
      0: v = (mMode == 2 ? 32'd1 : 32'd0) + (mHold ? 32'd2 : 32'd0) + (mMode == 1 ? 32'd4 : 32'd0);
      1: v = mHold ? 32'd1 : 32'd0;
      2: v = mDram;
      3: v = mEntry;
`ifdef BOOTCTRL_CYCLE_COUNTER_EN
      4: v = mRunCycles;
`endif
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] byteWrite(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  be);
    logic [31:0] mask;
    mask = 32'd0;
    if (be[0]) mask = mask | 32'h0000_00FF;
    if (be[1]) mask = mask | 32'h0000_FF00;
    if (be[2]) mask = mask | 32'h00FF_0000;
    if (be[3]) mask = mask | 32'hFF00_0000;
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelStep();
    bit isCtrl;
    bit startW;
    bit stopW;
    bit holdNow;
    int w;
    if (ARST) begin
      mMode      = 0;
      mPulseLeft = 0;
      mHold      = 1'b1;
      mDram      = 32'd0;
      mEntry     = 32'd0;
      mRdata     = 32'd0;
      mRunCycles = 32'd0;
      return;
    end
    if (RDEN) mRdata = modelRead(RDADDR);
    w      = WREN ? windowWord(WRADDR) : -1;
    isCtrl = (w == 1) && BYTEEN[0];
    startW = isCtrl && WDATA[1];
    stopW  = isCtrl && WDATA[2];
    if (w == 2) mDram = byteWrite(mDram, WDATA, BYTEEN);
    if (w == 3) mEntry = byteWrite(mEntry, WDATA, BYTEEN) & 32'hFFFF_FFFC;
    if (isCtrl) mHold = WDATA[0];
    holdNow = mHold;
    if (mMode == 2) mRunCycles = mRunCycles + 32'd1;
    if (holdNow) begin
      mMode = 0;
    end else if (stopW && mMode != 0) begin
      mMode = 0;
    end else if (startW) begin
      mMode      = 1;
      mPulseLeft = NCYC;
    end else if (mMode == 1) begin
      mPulseLeft--;
      if (mPulseLeft == 0) begin
        mMode      = 2;
        mRunCycles = 32'd0;
      end
    end
  endtask

  // Drive one cycle of bus activity, clock it, update the model and compare
  task automatic applyStimulus(input logic rst, input logic wen,
                               input logic [15:0] waddr, input logic [3:0] be,
                               input logic [31:0] wdat, input logic ren,
                               input logic [15:0] raddr);
    ARST   = rst;
    WREN   = wen;
    WRADDR = waddr;
    BYTEEN = be;
    WDATA  = wdat;
    RDEN   = ren;
    RDADDR = raddr;
    @(posedge ACLK);
    modelStep();
    #1;
    checkOutput("core_rst", {31'd0, core_rst}, (mMode != 2) ? 32'd1 : 32'd0);
    checkOutput("core_run", {31'd0, core_run}, (mMode == 2) ? 32'd1 : 32'd0);
    checkOutput("dram_base", dram_base, mDram);
    checkOutput("entry_pc", entry_pc, mEntry);
    checkOutput("rdata", RDATA, mRdata);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, be, data, 1'b0, 16'h0);
  endtask

  task automatic busRead(input logic [15:0] addr);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b1, addr);
  endtask

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return 16'($urandom);
      1:       return BASE + 16'd32 + 16'($urandom_range(0, 31));
      default: return BASE + 16'($urandom_range(0, 31));
    endcase
  endfunction

  // Main sequence: directed scenarios then randomized traffic
  initial begin
    int          pulseLen;
    logic [31:0] cyc;
    logic [15:0] wa;
    logic [31:0] wd;

    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0, 16'h0);
    checkOutput("reset_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("reset_core_run", {31'd0, core_run}, 32'd0);
    checkOutput("reset_rdata", RDATA, 32'd0);

    busRead(BASE + 16'h0);
    checkOutput("reset_status", RDATA, 32'h2);
    busRead(BASE + 16'h8);
    checkOutput("reset_drambase", RDATA, 32'h0);
    busRead(BASE + 16'hC);
    checkOutput("reset_entrypc", RDATA, 32'h0);

    busWrite(BASE + 16'h8, 4'hF, 32'h2000_0000);
    busWrite(BASE + 16'hC, 4'hF, 32'h0000_0103);
    busRead(BASE + 16'h8);
    checkOutput("drambase_rb", RDATA, 32'h2000_0000);
    busRead(BASE + 16'hC);
    checkOutput("entrypc_rb", RDATA, 32'h0000_0100);
    busWrite(BASE + 16'h8, 4'h2, 32'hAABB_CCDD);
    busRead(BASE + 16'h8);
    checkOutput("drambase_partial", RDATA, 32'h2000_CC00);

    // Read-during-write returns the previous value
    applyStimulus(1'b0, 1'b1, BASE + 16'hC, 4'hF, 32'h0000_0204, 1'b1, BASE + 16'hC);
    checkOutput("rdw_old", RDATA, 32'h0000_0100);

    // START and measure how long core_rst stays high
    busWrite(BASE + 16'h4, 4'h1, 32'h2);
    pulseLen = 0;
    for (int i = 0; i < 40 && core_rst; i++) begin
      pulseLen++;
      idleCycles(1);
    end
    checkOutput("pulse_len", pulseLen, NCYC);
    busRead(BASE + 16'h0);
    checkOutput("status_run", RDATA, 32'h1);

    // Restart from RUN, STATUS shows busy during the pulse
    busWrite(BASE + 16'h4, 4'h1, 32'h2);
    busRead(BASE + 16'h0);
    checkOutput("status_busy", RDATA, 32'h4);
    idleCycles(NCYC + 2);
    checkOutput("run_again", {31'd0, core_run}, 32'd1);

    // STOP, then START with hold set stays idle
    busWrite(BASE + 16'h4, 4'h1, 32'h4);
    checkOutput("stop_rst", {31'd0, core_rst}, 32'd1);
    busWrite(BASE + 16'h4, 4'h1, 32'h3);
    busRead(BASE + 16'h0);
    checkOutput("hold_status", RDATA, 32'h2);

    // CTRL write without byte lane 0 does nothing
    busWrite(BASE + 16'h4, 4'hE, 32'h2);
    busRead(BASE + 16'h0);
    checkOutput("ctrl_be0", RDATA, 32'h2);

    // Reset in the middle of a pulse
    busWrite(BASE + 16'h4, 4'h1, 32'h2);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0, 16'h0);
    checkOutput("midreset_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("midreset_dram", dram_base, 32'h0);
    busRead(BASE + 16'h0);
    checkOutput("midreset_status", RDATA, 32'h2);

    // Cycle counter after about 100 cycles in RUN
    busWrite(BASE + 16'h4, 4'h1, 32'h2);
    idleCycles(NCYC + 100);
    busRead(BASE + 16'h10);
    cyc = RDATA;
`ifdef BOOTCTRL_CYCLE_COUNTER_EN
    checkOutput("cycles_range", (cyc >= 32'd98 && cyc <= 32'd102) ? 32'd1 : 32'd0, 32'd1);
`else
    checkOutput("cycles_off", cyc, 32'd0);
`endif

    // Out-of-window accesses
    busWrite(BASE + 16'h20, 4'hF, 32'hFFFF_FFFF);
    busWrite(16'h0FFC, 4'hF, 32'hFFFF_FFFF);
    busWrite(BASE + 16'h28, 4'hF, 32'hFFFF_FFFF);
    checkOutput("oow_dram", dram_base, 32'h0);
    busRead(BASE + 16'h20);
    checkOutput("oow_rd_hi", RDATA, 32'h0);
    busRead(BASE + 16'h8);
    busRead(16'h0FFC);
    checkOutput("oow_rd_lo", RDATA, 32'h0);
    busRead(BASE + 16'h1C);
    checkOutput("unmapped_rd", RDATA, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wa = randAddr();
      wd = $urandom;
      if (windowWord(wa) == 1) wd[0] = ($urandom_range(0, 9) == 0);
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 30),
                    wa, 4'($urandom), wd,
                    ($urandom_range(0, 1) == 1),
                    randAddr());
    end

    $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
